axi_wr_arbiter: RTL and testbench
=================================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 4, meaning AXI ID width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, meaning address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning data width; WSTRB width is DATA_WIDTH/8.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset: ACLK  input  1  rising-edge clock.
REQ-005 ARESETn  input  1  synchronous active-low reset, sampled on ACLK rising edge.
REQ-006 S_AWID/S_AWADDR/S_AWLEN/S_AWSIZE/S_AWBURST  input  2x{ID_WIDTH,ADDR_WIDTH,8,3,2} packed  per-requester AW payload; requester r occupies slice r.
REQ-007 S_AWVALID  input  2  per-requester AW valid. S_AWREADY  output  2  per-requester AW ready.
REQ-008 S_WDATA/S_WSTRB  input  2x{DATA_WIDTH,DATA_WIDTH/8} packed  per-requester W payload.
REQ-009 S_WLAST/S_WVALID  input  2 each  per-requester W last/valid. S_WREADY  output  2  per-requester W ready.
REQ-010 S_BID/S_BRESP  output  ID_WIDTH/2  response payload, broadcast to both requesters.
REQ-011 S_BVALID  output  2  per-requester B valid. S_BREADY  input  2  per-requester B ready.
REQ-012 M_AWID/M_AWADDR/M_AWLEN/M_AWSIZE/M_AWBURST  output  ID_WIDTH/ADDR_WIDTH/8/3/2  AW payload to the memory slave; M_AWVALID  output  1; M_AWREADY  input  1.
REQ-013 M_WDATA/M_WSTRB/M_WLAST/M_WVALID  output  DATA_WIDTH/DATA_WIDTH/8/1/1  W channel to the slave; M_WREADY  input  1.
REQ-014 M_BID/M_BRESP/M_BVALID  input  ID_WIDTH/2/1  slave response; M_BREADY  output  1.
REQ-015 GNT  output  2  one-hot current owner, 2'b00 when idle. LEN_ERR  output  1  one-cycle pulse on WLAST/length mismatch.

Function
REQ-016 The block SHALL implement FSM states IDLE, ADDR, DATA, RESP; exactly one write transaction is in flight at any time.
REQ-017 IDLE: winner = requester with S_AWVALID set; if both set, the requester indicated by round-robin pointer PTR wins; S_AWREADY[winner]=1 combinationally in the same cycle; all other S_AWREADY bits are 0.
REQ-018 On the IDLE accept edge, the block SHALL register the winner's AW payload onto M_AW*, set GNT one-hot, clear beat counter BEATS, and go to ADDR.
REQ-019 ADDR: M_AWVALID=1 with stable payload until M_AWREADY=1 is sampled; on that edge go to DATA. AW latency is S_AWVALID accept -> M_AWVALID one cycle later.
REQ-020 DATA: M_WDATA/M_WSTRB/M_WVALID = the granted requester's slice; S_WREADY[g]=M_WREADY; S_WREADY of the non-granted requester = 0 (pass-through, zero added latency).
REQ-021 M_WLAST SHALL be generated as (BEATS == registered AWLEN); S_WLAST is not forwarded.
REQ-022 Each W handshake increments the 8-bit BEATS; on the handshake with BEATS==AWLEN go to RESP; if S_WLAST[g] disagrees with (BEATS==AWLEN) on any handshake, pulse LEN_ERR for one cycle and continue.
REQ-023 RESP: S_BVALID[g]=M_BVALID, M_BREADY=S_BREADY[g], S_BID/S_BRESP = M_BID/M_BRESP; on the M_BVALID&&M_BREADY edge go to IDLE, set PTR to the non-granted requester, and set GNT=2'b00.
REQ-024 Outside DATA, M_WVALID=0 and S_WREADY=2'b00; outside RESP, M_BREADY=0 and S_BVALID=2'b00; outside IDLE, S_AWREADY=2'b00.
REQ-025 A single active requester SHALL win regardless of PTR; PTR changes only on transaction completion.
REQ-026 AWLEN=0 SHALL give a one-beat burst with M_WLAST=1 on the first beat; AWLEN=255 SHALL give 256 beats with no counter overflow before the last beat.

Reset
REQ-027 While ARESETn=0 at a rising edge: state=IDLE, PTR=requester 0, GNT=0, BEATS=0, M_AWVALID=0, M_AW* payload=0, LEN_ERR=0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no completion or PTR update; all combinational outputs then follow the IDLE rules.

Verification
REQ-029 Single requester: S_AWVALID=2'b01, AWADDR=0x10, AWLEN=3, INCR -> GNT=01, M_AWVALID one cycle after accept, 4 W beats with M_WLAST on beat 4 only, S_BVALID[0] pass-through, return to IDLE.
REQ-030 Contention: both S_AWVALID high continuously, AWLEN=0 each -> grants alternate 01,10,01,10; the first grant after reset goes to requester 0.
REQ-031 Isolation: during requester 0's burst, requester 1 drives S_WVALID=1 -> S_WREADY[1]=0 and M_WDATA carries only requester 0's data.
REQ-032 Length mismatch: AWLEN=1, requester drives S_WLAST=1 on beat 1 -> LEN_ERR pulses once, M_WLAST asserted on beat 2, transaction completes.
REQ-033 Backpressure: M_AWREADY held low 5 cycles, M_WREADY toggling, M_BVALID delayed 3 cycles -> payload stable while valid and not ready, and no beats lost or duplicated.
REQ-034 Reset in DATA after beat 2 of AWLEN=7 -> next cycle M_AWVALID=0, GNT=0, and a new request to requester 0 is accepted normally.

Source files
------------

// File: rtl/axi_wr_arbiter_if.sv
// Bus bundle for the two-requester AXI write arbiter: per-requester S_* slices
// toward the requesters and a single M_* write channel toward the memory slave.
interface axi_wr_arbiter_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [1:0][ID_WIDTH-1:0]     S_AWID;
    logic [1:0][ADDR_WIDTH-1:0]   S_AWADDR;
    logic [1:0][7:0]              S_AWLEN;
    logic [1:0][2:0]              S_AWSIZE;
    logic [1:0][1:0]              S_AWBURST;
    logic [1:0]                   S_AWVALID;
    logic [1:0]                   S_AWREADY;
    logic [1:0][DATA_WIDTH-1:0]   S_WDATA;
    logic [1:0][DATA_WIDTH/8-1:0] S_WSTRB;
    logic [1:0]                   S_WLAST;
    logic [1:0]                   S_WVALID;
    logic [1:0]                   S_WREADY;
    logic [ID_WIDTH-1:0]          S_BID;
    logic [1:0]                   S_BRESP;
    logic [1:0]                   S_BVALID;
    logic [1:0]                   S_BREADY;

    logic [ID_WIDTH-1:0]          M_AWID;
    logic [ADDR_WIDTH-1:0]        M_AWADDR;
    logic [7:0]                   M_AWLEN;
    logic [2:0]                   M_AWSIZE;
    logic [1:0]                   M_AWBURST;
    logic                         M_AWVALID;
    logic                         M_AWREADY;
    logic [DATA_WIDTH-1:0]        M_WDATA;
    logic [DATA_WIDTH/8-1:0]      M_WSTRB;
    logic                         M_WLAST;
    logic                         M_WVALID;
    logic                         M_WREADY;
    logic [ID_WIDTH-1:0]          M_BID;
    logic [1:0]                   M_BRESP;
    logic                         M_BVALID;
    logic                         M_BREADY;

    // Arbiter side.
    modport slave (
        input  S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
        input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID, S_BREADY,
        output S_AWREADY, S_WREADY, S_BID, S_BRESP, S_BVALID,
        output M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWVALID,
        output M_WDATA, M_WSTRB, M_WLAST, M_WVALID, M_BREADY,
        input  M_AWREADY, M_WREADY, M_BID, M_BRESP, M_BVALID
    );

    // Environment side: requesters plus memory slave.
    modport master (
        output S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID,
        output S_WDATA, S_WSTRB, S_WLAST, S_WVALID, S_BREADY,
        input  S_AWREADY, S_WREADY, S_BID, S_BRESP, S_BVALID,
        input  M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWVALID,
        input  M_WDATA, M_WSTRB, M_WLAST, M_WVALID, M_BREADY,
        output M_AWREADY, M_WREADY, M_BID, M_BRESP, M_BVALID
    );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write arbiter: one transaction in flight, round-robin on
// contention, W/B pass-through to the owner, locally generated WLAST.
module axi_wr_arbiter #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    axi_wr_arbiter_if.slave bus,
    output logic [1:0]      GNT,
    output logic            LEN_ERR
);
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state;
    logic                    ptr, gidx, win, any_vld, wlast_exp, w_hs, b_hs;
    logic [7:0]              beats;
    logic [ID_WIDTH-1:0]     awid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [7:0]              awlen_q;
    logic [2:0]              awsize_q;
    logic [1:0]              awburst_q;
    logic                    awvalid_q;
    logic [DATA_WIDTH-1:0]   wdata_sel;
    logic [DATA_WIDTH/8-1:0] wstrb_sel;
    logic [NUM_REQ-1:0]      awready, wready, bvalid;

    // Lone requester always wins; PTR only breaks ties.
    assign any_vld   = |bus.S_AWVALID;
    assign win       = (&bus.S_AWVALID) ? ptr : ~bus.S_AWVALID[0];
    assign wlast_exp = (beats == awlen_q);

    assign wdata_sel = bus.S_WDATA[gidx];
    assign wstrb_sel = bus.S_WSTRB[gidx];

    assign bus.M_AWID    = awid_q;
    assign bus.M_AWADDR  = awaddr_q;
    assign bus.M_AWLEN   = awlen_q;
    assign bus.M_AWSIZE  = awsize_q;
    assign bus.M_AWBURST = awburst_q;
    assign bus.M_AWVALID = awvalid_q;

    assign bus.M_WDATA   = wdata_sel;
    assign bus.M_WSTRB   = wstrb_sel;
    assign bus.M_WVALID  = (state == DATA) && bus.S_WVALID[gidx];
    assign bus.M_WLAST   = (state == DATA) && wlast_exp;
    assign w_hs          = bus.M_WVALID && bus.M_WREADY;

    assign bus.M_BREADY  = (state == RESP) && bus.S_BREADY[gidx];
    assign b_hs          = bus.M_BVALID && bus.M_BREADY;
    assign bus.S_BID     = bus.M_BID;
    assign bus.S_BRESP   = bus.M_BRESP;

    always_comb begin
        awready = '0;
        wready  = '0;
        bvalid  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            awready[r] = (state == IDLE) && any_vld && (win == 1'(r));
            wready[r]  = (state == DATA) && (gidx == 1'(r)) && bus.M_WREADY;
            bvalid[r]  = (state == RESP) && (gidx == 1'(r)) && bus.M_BVALID;
        end
    end

    assign bus.S_AWREADY = awready;
    assign bus.S_WREADY  = wready;
    assign bus.S_BVALID  = bvalid;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            gidx      <= 1'b0;
            GNT       <= 2'b00;
            beats     <= '0;
            awvalid_q <= 1'b0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            LEN_ERR   <= 1'b0;
        end else begin
            LEN_ERR <= 1'b0;
            case (state)
                IDLE: if (any_vld) begin
                    gidx      <= win;
                    GNT       <= win ? 2'b10 : 2'b01;
                    beats     <= '0;
                    awid_q    <= bus.S_AWID[win];
                    awaddr_q  <= bus.S_AWADDR[win];
                    awlen_q   <= bus.S_AWLEN[win];
                    awsize_q  <= bus.S_AWSIZE[win];
                    awburst_q <= bus.S_AWBURST[win];
                    awvalid_q <= 1'b1;
                    state     <= ADDR;
                end
                ADDR: if (bus.M_AWREADY) begin
                    awvalid_q <= 1'b0;
                    state     <= DATA;
                end
                // Beat count, not requester WLAST, ends the burst; mismatch is only flagged.
                DATA: if (w_hs) begin
                    beats <= beats + 8'd1;
                    if (bus.S_WLAST[gidx] != wlast_exp) LEN_ERR <= 1'b1;
                    if (wlast_exp) state <= RESP;
                end
                RESP: if (b_hs) begin
                    state <= IDLE;
                    ptr   <= ~gidx;
                    GNT   <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Scoreboard bench for axi_wr_arbiter: directed requester traffic, a reactive
// memory-slave model, and a negedge monitor popping expected AW/W/B entries.
module tb_axi_wr_arbiter;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;

    typedef struct packed {
        logic [1:0]     gnt;
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
    } aw_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic            last;
    } w_t;

    typedef struct packed {
        logic [1:0]     bvalid;
        logic [IDW-1:0] id;
        logic [1:0]     resp;
    } b_t;

    logic       ACLK = 1'b0;
    logic       ARESETn;
    logic [1:0] GNT;
    logic       LEN_ERR;

    aw_t aw_q[$];
    w_t  w_q[$];
    b_t  b_q[$];

    int tests = 0;
    int fails = 0;
    int lerr_cnt = 0;
    int aw_delay = 0;
    int b_delay = 0;
    bit wr_toggle = 1'b0;
    logic [1:0] slave_resp = 2'b00;

    axi_wr_arbiter_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi_wr_arbiter #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus),
        .GNT     (GNT),
        .LEN_ERR (LEN_ERR)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int r, input int ch, output bit ok);
        logic rdy;
        int   n = 0;
        ok = 1'b0;
        while (!ok && n < 300) begin
            @(negedge ACLK);
            rdy = (ch == 0) ? bus.S_AWREADY[r] : bus.S_WREADY[r];
            @(posedge ACLK);
            #1;
            ok = rdy;
            n++;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: req %0d got no ready, expected ready within 300 cycles",
                     (ch == 0) ? "aw" : "w", r);
        end
    endtask

    task automatic exp_write(input int r, input int id, input int addr, input int len,
                             input logic [31:0] base, input logic [1:0] resp);
        aw_q.push_back('{gnt: 2'(1 << r), id: IDW'(id), addr: AW'(addr), len: 8'(len),
                         size: 3'd2, burst: 2'd1});
        for (int i = 0; i <= len; i++)
            w_q.push_back('{data: base + 32'(i), strb: 4'hF, last: (i == len)});
        b_q.push_back('{bvalid: 2'(1 << r), id: IDW'(id), resp: resp});
    endtask

    // bad: beat index whose WLAST is inverted (-1 for none)
    task automatic req_write(input int r, input int id, input int addr, input int len,
                             input logic [31:0] base, input int bad);
        bit ok;
        bus.S_AWID[r]    = IDW'(id);
        bus.S_AWADDR[r]  = AW'(addr);
        bus.S_AWLEN[r]   = 8'(len);
        bus.S_AWSIZE[r]  = 3'd2;
        bus.S_AWBURST[r] = 2'd1;
        bus.S_AWVALID[r] = 1'b1;
        wait_ready(r, 0, ok);
        bus.S_AWVALID[r] = 1'b0;
        if (!ok) return;
        for (int i = 0; i <= len; i++) begin
            bus.S_WDATA[r]  = base + 32'(i);
            bus.S_WSTRB[r]  = 4'hF;
            bus.S_WLAST[r]  = (i == len) ^ (i == bad);
            bus.S_WVALID[r] = 1'b1;
            wait_ready(r, 1, ok);
            if (!ok) break;
        end
        bus.S_WVALID[r] = 1'b0;
        bus.S_WLAST[r]  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((aw_q.size() + w_q.size() + b_q.size()) != 0 && n < 2000) begin
            @(posedge ACLK);
            n++;
        end
        if (n >= 2000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d entries pending, expected 0",
                     aw_q.size() + w_q.size() + b_q.size());
        end
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    // Memory slave: AWREADY after aw_delay cycles of AWVALID
    initial begin
        int cnt;
        cnt = 0;
        bus.M_AWREADY = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            if (bus.M_AWVALID && cnt < aw_delay) begin
                bus.M_AWREADY = 1'b0;
                cnt++;
            end else if (bus.M_AWVALID) begin
                bus.M_AWREADY = 1'b1;
            end else begin
                bus.M_AWREADY = 1'b0;
                cnt = 0;
            end
        end
    end

    initial begin
        bus.M_WREADY = 1'b0;
        forever begin
            @(posedge ACLK);
            #1;
            bus.M_WREADY = wr_toggle ? ~bus.M_WREADY : 1'b1;
        end
    end

    // Memory slave B channel: respond b_delay cycles after the last beat
    initial begin
        logic [IDW-1:0] cur_id;
        logic           got;
        int             n;
        cur_id = '0;
        bus.M_BVALID = 1'b0;
        bus.M_BID    = '0;
        bus.M_BRESP  = 2'b00;
        forever begin
            @(negedge ACLK);
            if (ARESETn && bus.M_AWVALID && bus.M_AWREADY) cur_id = bus.M_AWID;
            if (ARESETn && bus.M_WVALID && bus.M_WREADY && bus.M_WLAST) begin
                @(posedge ACLK);
                #1;
                repeat (b_delay) begin
                    @(posedge ACLK);
                    #1;
                end
                bus.M_BVALID = 1'b1;
                bus.M_BID    = cur_id;
                bus.M_BRESP  = slave_resp;
                n = 0;
                got = 1'b0;
                while (!got && n < 200) begin
                    @(negedge ACLK);
                    got = bus.M_BREADY;
                    @(posedge ACLK);
                    #1;
                    n++;
                end
                if (!got) begin
                    tests++;
                    fails++;
                    $display("FAIL bready_timeout: got no M_BREADY, expected within 200 cycles");
                end
                bus.M_BVALID = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        aw_t         ea;
        w_t          ew;
        b_t          eb;
        logic        acc_pend, aw_hold;
        logic [48:0] aw_saved;
        acc_pend = 1'b0;
        aw_hold  = 1'b0;
        aw_saved = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                acc_pend = 1'b0;
                aw_hold  = 1'b0;
            end else begin
                if (LEN_ERR) lerr_cnt++;
                if (acc_pend) check("aw_latency", bus.M_AWVALID, 1);
                acc_pend = |(bus.S_AWVALID & bus.S_AWREADY);
                if (aw_hold && bus.M_AWVALID)
                    check("aw_stable", {bus.M_AWID, bus.M_AWADDR, bus.M_AWLEN,
                                        bus.M_AWSIZE, bus.M_AWBURST}, aw_saved);
                aw_hold  = bus.M_AWVALID && !bus.M_AWREADY;
                aw_saved = {bus.M_AWID, bus.M_AWADDR, bus.M_AWLEN, bus.M_AWSIZE, bus.M_AWBURST};
                if (bus.M_AWVALID && bus.M_AWREADY) begin
                    if (aw_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL aw_unexpected: got AW handshake, expected none");
                    end else begin
                        ea = aw_q.pop_front();
                        check("aw", {GNT, bus.M_AWID, bus.M_AWADDR, bus.M_AWLEN,
                                     bus.M_AWSIZE, bus.M_AWBURST}, ea);
                    end
                end
                if (bus.M_WVALID && bus.M_WREADY) begin
                    if (w_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL w_unexpected: got W beat %0h, expected none", bus.M_WDATA);
                    end else begin
                        ew = w_q.pop_front();
                        check("w_beat", {bus.M_WDATA, bus.M_WSTRB, bus.M_WLAST}, ew);
                    end
                end
                if (|(bus.S_BVALID & bus.S_BREADY)) begin
                    if (b_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL b_unexpected: got B valid %0b, expected none", bus.S_BVALID);
                    end else begin
                        eb = b_q.pop_front();
                        check("b_resp", {bus.S_BVALID, bus.S_BID, bus.S_BRESP}, eb);
                    end
                end
                for (int r = 0; r < 2; r++)
                    if (bus.S_WVALID[r] && !GNT[r]) check("wready_iso", bus.S_WREADY[r], 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bus.S_AWID = '0; bus.S_AWADDR = '0; bus.S_AWLEN = '0; bus.S_AWSIZE = '0;
        bus.S_AWBURST = '0; bus.S_AWVALID = '0; bus.S_WDATA = '0; bus.S_WSTRB = '0;
        bus.S_WLAST = '0; bus.S_WVALID = '0; bus.S_BREADY = 2'b11;
        ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_gnt", GNT, 0);
        check("rst_awvalid", bus.M_AWVALID, 0);
        check("rst_awaddr", bus.M_AWADDR, 0);
        check("rst_len_err", LEN_ERR, 0);
        check("rst_wready", bus.S_WREADY, 0);
        check("rst_bvalid", bus.S_BVALID, 0);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;

        // Contention straight after reset: 01,10,01,10
        exp_write(0, 2, 'h500, 0, 32'h5000_0000, 2'b00);
        exp_write(1, 6, 'h510, 0, 32'h5100_0000, 2'b00);
        exp_write(0, 4, 'h520, 0, 32'h5200_0000, 2'b00);
        exp_write(1, 8, 'h530, 0, 32'h5300_0000, 2'b00);
        fork
            begin
                req_write(0, 2, 'h500, 0, 32'h5000_0000, -1);
                req_write(0, 4, 'h520, 0, 32'h5200_0000, -1);
            end
            begin
                req_write(1, 6, 'h510, 0, 32'h5100_0000, -1);
                req_write(1, 8, 'h530, 0, 32'h5300_0000, -1);
            end
        join
        wait_idle();

        // Single requester, 4-beat INCR
        exp_write(0, 3, 'h10, 3, 32'hA000_0000, 2'b00);
        req_write(0, 3, 'h10, 3, 32'hA000_0000, -1);
        wait_idle();
        check("idle_gnt", GNT, 0);

        // Isolation: requester 1 drives W junk during requester 0's burst (PTR favours 1)
        bus.S_WDATA[1]  = 32'hDEAD_BEEF;
        bus.S_WSTRB[1]  = 4'h1;
        bus.S_WLAST[1]  = 1'b1;
        bus.S_WVALID[1] = 1'b1;
        exp_write(0, 5, 'h200, 2, 32'hB000_0000, 2'b00);
        req_write(0, 5, 'h200, 2, 32'hB000_0000, -1);
        wait_idle();
        bus.S_WVALID[1] = 1'b0;
        bus.S_WLAST[1]  = 1'b0;

        // Length mismatch: early WLAST on first beat of a 2-beat burst
        exp_write(0, 1, 'h300, 1, 32'hC000_0000, 2'b00);
        req_write(0, 1, 'h300, 1, 32'hC000_0000, 0);
        wait_idle();
        check("len_err_pulses", lerr_cnt, 1);

        // Backpressure on all three slave channels
        aw_delay = 5; wr_toggle = 1'b1; b_delay = 3; slave_resp = 2'b10;
        exp_write(1, 9, 'h400, 3, 32'hD000_0000, 2'b10);
        req_write(1, 9, 'h400, 3, 32'hD000_0000, -1);
        wait_idle();
        aw_delay = 0; wr_toggle = 1'b0; b_delay = 0; slave_resp = 2'b00;

        // Maximum burst length
        exp_write(1, 11, 'h1000, 255, 32'h1000_0000, 2'b00);
        req_write(1, 11, 'h1000, 255, 32'h1000_0000, -1);
        wait_idle();

        // Reset in DATA after beat 2 of an 8-beat burst
        aw_q.push_back('{gnt: 2'b01, id: 4'hC, addr: 32'h600, len: 8'd7, size: 3'd2, burst: 2'd1});
        w_q.push_back('{data: 32'hE000_0000, strb: 4'hF, last: 1'b0});
        w_q.push_back('{data: 32'hE000_0001, strb: 4'hF, last: 1'b0});
        bus.S_AWID[0] = 4'hC; bus.S_AWADDR[0] = 32'h600; bus.S_AWLEN[0] = 8'd7;
        bus.S_AWSIZE[0] = 3'd2; bus.S_AWBURST[0] = 2'd1; bus.S_AWVALID[0] = 1'b1;
        wait_ready(0, 0, ok);
        bus.S_AWVALID[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.S_WDATA[0] = 32'hE000_0000 + 32'(i);
            bus.S_WSTRB[0] = 4'hF;
            bus.S_WLAST[0] = 1'b0;
            bus.S_WVALID[0] = 1'b1;
            wait_ready(0, 1, ok);
        end
        ARESETn = 1'b0;
        bus.S_WVALID[0] = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("rst_mid_awvalid", bus.M_AWVALID, 0);
        check("rst_mid_gnt", GNT, 0);
        check("rst_mid_wvalid", bus.M_WVALID, 0);
        check("rst_mid_pending", aw_q.size() + w_q.size(), 0);
        aw_q.delete();
        w_q.delete();
        @(posedge ACLK);
        #1;
        exp_write(0, 7, 'h700, 0, 32'hF000_0000, 2'b00);
        req_write(0, 7, 'h700, 0, 32'hF000_0000, -1);
        wait_idle();

        check("len_err_total", lerr_cnt, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
